// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store width codes and the MEM-stage access states.
package cpu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Picks the addressed byte/half of a loaded word and sign- or zero-extends it.
module load_extend
    import cpu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_i[7:0];
        case (addr_i)
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            2'd3:    byte_sel = raw_i[31:24];
            default: byte_sel = raw_i[7:0];
        endcase
        half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM-stage data-memory handshake controller plus the MEM/WB pipeline register.
// valid/ready: dm_req is held from issue until the cycle dm_ack is seen in WAIT; dm_ack outside WAIT is ignored.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MEM_ALU_out,
    input  logic [31:0] MEM_R_ALUout,
    input  logic [4:0]  MEM_write_addr,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_pc,
    input  logic        MEM_RDSrc,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemRead,
    input  logic        MEM_write_signal,
    input  logic        MEM_RegWrite,
    input  logic        MEM_f_RegWrite,
    input  logic        im_stall,
    input  logic        CSR_stall,
    input  logic        CSR_reset,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        dm_req,
    output logic        dm_stall,
    output logic        dm_err,
    output logic [31:0] WB_rd_data,
    output logic [4:0]  WB_write_addr,
    output logic        WB_RegWrite,
    output logic        WB_f_RegWrite,
    output logic [1:0]  dbg_state_o
);

    localparam logic [7:0] LIMIT    = 8'(WAIT_LIMIT);
    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] held_q, held_d;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_addr_q;
    logic        wb_rw_q, wb_frw_q;

    logic        access, advance, pipe_free, in_idle, in_wait;
    logic [31:0] raw_word, load_data, wb_sel;

    assign access    = MEM_MemRead | MEM_write_signal;
    assign pipe_free = ~im_stall & ~CSR_stall;
    assign in_idle   = (state_q == IDLE);
    assign in_wait   = (state_q == WAIT);

    // Gated by reset so a held access cannot keep the request up while the core is in reset.
    assign dm_req   = ~reset & ((in_idle & access) | in_wait);
    assign dm_stall = ~reset & ((in_idle & access) | (in_wait & ~dm_ack));
    assign dm_err   = ~reset & in_wait & ~dm_ack & (cnt_q == LIMIT_M1);
    assign advance  = pipe_free & ~dm_stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (dm_ack) begin
                    held_d  = dm_rdata;
                    state_d = pipe_free ? IDLE : DONE;
                end else if (cnt_q == LIMIT_M1) begin
                    held_d  = '0;
                    state_d = DONE;
                end
                if (!dm_ack && cnt_q != LIMIT) cnt_d = cnt_q + 8'd1;
            end
            DONE: begin
                if (pipe_free) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
        end else if (CSR_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    // Bypass the capture register on the ack cycle so the load can retire immediately.
    assign raw_word = (in_wait & dm_ack) ? dm_rdata : held_q;

    load_extend u_load_extend (
        .raw_i    (raw_word),
        .funct3_i (MEM_funct3),
        .addr_i   (MEM_ALU_out[1:0]),
        .data_o   (load_data)
    );

    always_comb begin
        if (MEM_MemtoReg)        wb_sel = load_data;
        else if (MEM_f_RegWrite) wb_sel = MEM_R_ALUout;
        else if (MEM_RDSrc)      wb_sel = MEM_pc + 32'd4;
        else                     wb_sel = MEM_ALU_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_rw_q   <= 1'b0;
            wb_frw_q  <= 1'b0;
        end else if (CSR_reset) begin
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_rw_q   <= 1'b0;
            wb_frw_q  <= 1'b0;
        end else if (advance) begin
            wb_data_q <= wb_sel;
            wb_addr_q <= MEM_write_addr;
            wb_rw_q   <= MEM_RegWrite;
            wb_frw_q  <= MEM_f_RegWrite;
        end
    end

    assign WB_rd_data    = wb_data_q;
    assign WB_write_addr = wb_addr_q;
    assign WB_RegWrite   = wb_rw_q;
    assign WB_f_RegWrite = wb_frw_q;
    assign dbg_state_o   = state_q;

endmodule
